// File: rtl/seq_det_pkg.sv
// Shared limits and state encoding for the serial sequence detector.
// Imported by seq_detector_param and seq_det_sat_counter.
package seq_det_pkg;

  localparam int SEQ_LEN_MIN   = 2;
  localparam int SEQ_LEN_MAX   = 16;
  localparam int CNT_WIDTH_MAX = 16;

  // FILLING: history not yet full; ARMED: every valid bit is evaluated
  localparam logic [0:0] FILLING = 1'b0;
  localparam logic [0:0] ARMED   = 1'b1;

endpackage

// File: rtl/seq_det_sat_counter.sv
// Saturating detection counter; holds at all ones instead of wrapping.
// Built only when SEQ_DET_COUNT_EN is defined.
module seq_det_sat_counter
  import seq_det_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             sat
);

  if (WIDTH < 1 || WIDTH > CNT_WIDTH_MAX) begin : g_bad_width
    $error("seq_det_sat_counter: WIDTH out of range");
  end

  assign sat = &count;

  // Count detections; clear wins over inc, saturate at all ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial masked-pattern detector with overlap select and detection count.
// Macro SEQ_DET_COUNT_EN builds the counter; otherwise count/cnt_sat are 0.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int SEQ_LEN   = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 data_valid,
  input  logic                 data,
  input  logic [SEQ_LEN-1:0]   pattern,
  input  logic [SEQ_LEN-1:0]   mask,
  input  logic                 overlap_en,
  input  logic                 clear,
  output logic                 detected,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 cnt_sat
);

  localparam int FW = $clog2(SEQ_LEN + 1);

  if (SEQ_LEN < SEQ_LEN_MIN || SEQ_LEN > SEQ_LEN_MAX) begin : g_bad_len
    $error("seq_detector_param: SEQ_LEN out of range");
  end

  logic [SEQ_LEN-1:0] hist;
  logic [SEQ_LEN-1:0] next_hist;
  logic [FW-1:0]      fill;
  logic [FW-1:0]      next_fill;
  logic [0:0]         state;
  logic               match;

  // Candidate history/fill for this edge and the masked compare on it
  always_comb begin
    state     = (fill == FW'(SEQ_LEN)) ? ARMED : FILLING;
    next_hist = {hist[SEQ_LEN-2:0], data};
    next_fill = (state == ARMED) ? fill : fill + FW'(1);
    match     = (next_fill == FW'(SEQ_LEN)) &&
                (((next_hist ^ pattern) & mask) == '0);
  end

  // History shift, fill tracking and the registered match pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist     <= '0;
      fill     <= '0;
      detected <= 1'b0;
    end else if (clear) begin
      hist     <= '0;
      fill     <= '0;
      detected <= 1'b0;
    end else if (data_valid) begin
      detected <= match;
      if (match && !overlap_en) begin
        hist <= '0;
        fill <= '0;
      end else begin
        hist <= next_hist;
        fill <= next_fill;
      end
    end else begin
      detected <= 1'b0;
    end
  end

`ifdef SEQ_DET_COUNT_EN
  logic inc;

  assign inc = data_valid & ~clear & match;

  seq_det_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (inc),
    .count (count),
    .sat   (cnt_sat)
  );
`else
  assign count   = '0;
  assign cnt_sat = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param (SEQ_LEN=4, CNT_WIDTH=2).
// Count expectations follow SEQ_DET_COUNT_EN as seen by this compile.
module tb_seq_detector_param;

  localparam int SL = 4;
  localparam int CW = 2;
`ifdef SEQ_DET_COUNT_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          data_valid = 1'b0;
  logic          data = 1'b0;
  logic [SL-1:0] pattern = 4'b1011;
  logic [SL-1:0] mask = 4'b1111;
  logic          overlap_en = 1'b1;
  logic          clear = 1'b0;
  logic          detected;
  logic [CW-1:0] count;
  logic          cnt_sat;

  int errs = 0;
  int chks = 0;
  int exp_cnt = 0;

  seq_detector_param #(
    .SEQ_LEN   (SL),
    .CNT_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_valid (data_valid),
    .data       (data),
    .pattern    (pattern),
    .mask       (mask),
    .overlap_en (overlap_en),
    .clear      (clear),
    .detected   (detected),
    .count      (count),
    .cnt_sat    (cnt_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, ".cnt"}, int'(count), CE ? exp_cnt : 0);
    chk({tag, ".sat"}, int'(cnt_sat), (CE && exp_cnt == 3) ? 1 : 0);
  endtask

  // One clock: drive at negedge, check just after the posedge
  task automatic send(input bit v, input bit d, input bit ed,
                      input string tag);
    @(negedge clk);
    data_valid = v;
    data       = d;
    @(posedge clk);
    #1;
    if (ed && exp_cnt < 3) exp_cnt++;
    chk({tag, ".det"}, int'(detected), int'(ed));
    chk_cnt(tag);
  endtask

  task automatic send_seq(input logic [7:0] bits, input logic [7:0] eds,
                          input int n, input string tag);
    for (int i = n - 1; i >= 0; i--)
      send(1'b1, bits[i], eds[i], $sformatf("%s[%0d]", tag, n - 1 - i));
  endtask

  // Clear with a valid 1 on the line: it must not be sampled
  task automatic do_clear(input string tag);
    @(negedge clk);
    clear      = 1'b1;
    data_valid = 1'b1;
    data       = 1'b1;
    @(posedge clk);
    #1;
    exp_cnt = 0;
    chk({tag, ".det"}, int'(detected), 0);
    chk_cnt(tag);
    @(negedge clk);
    clear      = 1'b0;
    data_valid = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst.det", int'(detected), 0);
    chk("rst.cnt", int'(count), 0);
    chk("rst.sat", int'(cnt_sat), 0);
    @(negedge clk);
    reset = 1'b1;

    // Basic 1011
    send_seq(8'b1011, 8'b0001, 4, "basic");
    send(1'b0, 1'b1, 1'b0, "basic.idle");

    // Overlap on: two pulses
    do_clear("clr1");
    overlap_en = 1'b1;
    send_seq(8'b1011011, 8'b0001001, 7, "ovl1");

    // Overlap off: one pulse, history discarded
    do_clear("clr2");
    overlap_en = 1'b0;
    send_seq(8'b1011011, 8'b0001000, 7, "ovl0");
    overlap_en = 1'b1;

    // Gaps in valid do not break the sequence
    do_clear("clr3");
    send_seq(8'b10, 8'b00, 2, "gap.a");
    send(1'b0, 1'b1, 1'b0, "gap.v0");
    send(1'b0, 1'b0, 1'b0, "gap.v1");
    send(1'b0, 1'b1, 1'b0, "gap.v2");
    send_seq(8'b11, 8'b01, 2, "gap.b");

    // Mask don't-care
    do_clear("clr4");
    mask = 4'b1101;
    send_seq(8'b1001, 8'b0001, 4, "mask1101");
    do_clear("clr5");
    mask = 4'b1111;
    send_seq(8'b1001, 8'b0000, 4, "mask1111");

    // Async reset mid-sequence
    do_clear("clr6");
    send_seq(8'b101, 8'b000, 3, "rpre");
    @(negedge clk);
    reset = 1'b0;
    #1;
    exp_cnt = 0;
    chk("rmid.det", int'(detected), 0);
    chk_cnt("rmid");
    @(negedge clk);
    reset = 1'b1;
    send_seq(8'b1011, 8'b0001, 4, "rpost");

    // Clear mid-sequence
    do_clear("clr7");
    send_seq(8'b101, 8'b000, 3, "cpre");
    do_clear("cmid");
    send_seq(8'b1011, 8'b0001, 4, "cpost");

    // Mask all zero: every armed bit matches; counter saturates at 3
    do_clear("clr8");
    mask = 4'b0000;
    send_seq(8'b10110100, 8'b00011111, 8, "sat");
    mask = 4'b1111;

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 The block SHALL take parameter SEQ_LEN, default 4, as the detected sequence length in bits (legal range 2..16).
REQ-002 The block SHALL take parameter CNT_WIDTH, default 8, as the width of the detection counter (legal range 1..16).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-005 The block SHALL have port data_valid, input, 1 bit: data is sampled only on edges where this is 1.
REQ-006 The block SHALL have port data, input, 1 bit: serial input bit.
REQ-007 The block SHALL have port pattern, input, SEQ_LEN bits: the target sequence; pattern[SEQ_LEN-1] is the first bit received.
REQ-008 The block SHALL have port mask, input, SEQ_LEN bits: 1 means compare that position; 0 means don't-care.
REQ-009 The block SHALL have port overlap_en, input, 1 bit: 1 selects overlapping detection; 0 selects non-overlapping detection.
REQ-010 The block SHALL have port clear, input, 1 bit: synchronous flush of history, detected and count.
REQ-011 The block SHALL have port detected, output, 1 bit: registered one-cycle match pulse.
REQ-012 The block SHALL have port count, output, CNT_WIDTH bits: saturating count of detections.
REQ-013 The block SHALL have port cnt_sat, output, 1 bit: high while count equals all ones.

Function
REQ-014 The block SHALL hold a SEQ_LEN-bit history register hist and a fill counter (0..SEQ_LEN); a new bit shifts into hist[0] and the oldest bit sits at hist[SEQ_LEN-1].
REQ-015 The fill counter SHALL act as the state: FILLING while fill<SEQ_LEN, ARMED while fill==SEQ_LEN; FILLING moves to ARMED when the SEQ_LEN-th valid bit arrives.
REQ-016 On an edge with data_valid=1 and clear=0, the block SHALL form next_hist={hist[SEQ_LEN-2:0],data} and next_fill=min(fill+1,SEQ_LEN), and load both.
REQ-017 A match SHALL be defined as next_fill==SEQ_LEN with ((next_hist XOR pattern) AND mask)==0.
REQ-018 detected SHALL be registered: high for exactly the one cycle after the edge that samples the completing bit; latency is 1 cycle.
REQ-019 With overlap_en=1, a match SHALL leave fill at SEQ_LEN, so the block stays ARMED and the next valid bit may complete another match.
REQ-020 With overlap_en=0, a match SHALL force fill to 0 (FILLING), discarding the history.
REQ-021 On an edge with data_valid=0, hist and fill SHALL hold and detected SHALL be 0; gaps in valid data SHALL NOT break a sequence.
REQ-022 clear=1 SHALL take priority over data_valid: on that edge fill, detected and count go to 0, and data is not sampled.
REQ-023 pattern, mask and overlap_en SHALL NOT be latched; they apply on every evaluated edge, and a mid-stream change applies to the next sampled bit.
REQ-024 With mask all zero, every valid bit in the ARMED state SHALL produce a match.
REQ-025 count SHALL increment by 1 on each edge that sets detected, SHALL saturate at 2^CNT_WIDTH-1 with no wrap, and cnt_sat SHALL be count==all ones.

Reset
REQ-026 While reset=0, hist, fill, detected, count and cnt_sat SHALL all be 0 immediately, independent of clk.
REQ-027 If reset is asserted mid-sequence, the partial history SHALL be lost; detection resumes in FILLING with fill=0 on the first valid bit after reset deasserts.

Configuration
REQ-028 Macro SEQ_DET_COUNT_EN SHALL gate the counter: when defined, count and cnt_sat behave per REQ-025.
REQ-029 When SEQ_DET_COUNT_EN is undefined, count and cnt_sat ports SHALL remain present and be tied to 0, with no counter logic synthesised; detection behaviour is unchanged.

Structure
REQ-030 Package seq_det_pkg SHALL hold the limits SEQ_LEN_MIN=2, SEQ_LEN_MAX=16 and CNT_WIDTH_MAX=16, plus the named FILLING/ARMED state encoding.
REQ-031 The saturating counter SHALL be a sub-module, seq_det_sat_counter (params WIDTH; inputs clk, reset, clear, inc; outputs count, sat), instantiated only under SEQ_DET_COUNT_EN.

Verification
All scenarios use SEQ_LEN=4, pattern=4'b1011, mask=4'b1111 and data_valid=1 unless stated otherwise.
REQ-032 The bench SHALL check: reset, then stream 1,0,1,1 -> detected=1 for one cycle after the 4th edge, and count=1.
REQ-033 The bench SHALL check: stream 1,0,1,1,0,1,1 -> with overlap_en=1, two pulses (after bits 4 and 7) and count=2; with overlap_en=0, one pulse and count=1.
REQ-034 The bench SHALL check: stream 1,0, then data_valid=0 for 3 cycles with data toggling, then 1,1 -> one pulse, after the final bit.
REQ-035 The bench SHALL check: mask=4'b1101 and stream 1,0,0,1 -> detected pulse; mask=4'b1111 with the same stream -> no pulse.
REQ-036 The bench SHALL check: stream 1,0,1, then reset low for 1 cycle (or clear=1), then 1 -> no pulse; a following 0,1,1 still gives no pulse until 4 new valid bits are received.
REQ-037 The bench SHALL check: CNT_WIDTH=2 with SEQ_DET_COUNT_EN defined and 5 overlapping detections -> count=3, cnt_sat=1 from the 3rd detection on; without the macro, count=0 throughout.
